// File: rtl/vigna_axi_rd_arbiter.sv
// 2:1 AXI4-Lite read arbiter: instruction (i_*) and data (d_*) read ports onto one master port (m_*).
// Define VIGNA_AXI_ARB_RR_EN for alternating grant on ties; otherwise the data port wins every tie.
module vigna_axi_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_arvalid,
  output logic                  i_arready,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  output logic                  i_rvalid,
  input  logic                  i_rready,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic [1:0]            i_rresp,
  input  logic                  d_arvalid,
  output logic                  d_arready,
  input  logic [ADDR_WIDTH-1:0] d_araddr,
  output logic                  d_rvalid,
  input  logic                  d_rready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [1:0]            d_rresp,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp
);

  // state  | meaning
  // S_IDLE | no transaction, waiting for i/d arvalid
  // S_ADDR | merged AR presented downstream, waiting for m_arready
  // S_DATA | m_rready high, waiting for m_rvalid
  // S_RESP | winner rvalid held until winner rready
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t state, state_nxt;
  logic   grant_i;
  logic   win_i;
  logic   any_req;
  logic   resp_done;

  assign any_req   = i_arvalid | d_arvalid;
  assign resp_done = grant_i ? i_rready : d_rready;

`ifdef VIGNA_AXI_ARB_RR_EN
  logic last_grant_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_i <= 1'b1;
    end else if (state == S_RESP && resp_done) begin
      last_grant_i <= grant_i;
    end
  end

  // On a tie the port that was not served last time wins.
  assign win_i = i_arvalid & (~d_arvalid | ~last_grant_i);
`else
  assign win_i = i_arvalid & ~d_arvalid;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (any_req) state_nxt = S_ADDR;
      S_ADDR: if (m_arvalid && m_arready) state_nxt = S_DATA;
      S_DATA: if (m_rvalid) state_nxt = S_RESP;
      S_RESP: if (resp_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    m_rready = (state == S_DATA);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_i   <= 1'b0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arprot  <= 3'b000;
      i_arready <= 1'b0;
      d_arready <= 1'b0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_rresp   <= 2'b00;
      d_rresp   <= 2'b00;
    end else begin
      i_arready <= 1'b0;
      d_arready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant_i   <= win_i;
            m_araddr  <= win_i ? i_araddr : d_araddr;
            m_arprot  <= {win_i, 2'b00};
            m_arvalid <= 1'b1;
            i_arready <= win_i;
            d_arready <= ~win_i;
          end
        end
        S_ADDR: begin
          if (m_arready) m_arvalid <= 1'b0;
        end
        S_DATA: begin
          if (m_rvalid) begin
            if (grant_i) begin
              i_rvalid <= 1'b1;
              i_rdata  <= m_rdata;
              i_rresp  <= m_rresp;
            end else begin
              d_rvalid <= 1'b1;
              d_rdata  <= m_rdata;
              d_rresp  <= m_rresp;
            end
          end
        end
        S_RESP: begin
          if (resp_done) begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vigna_axi_rd_arbiter.sv
// Bench for vigna_axi_rd_arbiter: vector table of single reads plus tie, stall and reset sequences.
module tb_vigna_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_arvalid, i_arready, i_rvalid, i_rready;
  logic [31:0] i_araddr, i_rdata;
  logic [1:0]  i_rresp;
  logic        d_arvalid, d_arready, d_rvalid, d_rready;
  logic [31:0] d_araddr, d_rdata;
  logic [1:0]  d_rresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic [2:0]  m_arprot;
  logic [1:0]  m_rresp;

`ifdef VIGNA_AXI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  vigna_axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_arvalid(i_arvalid), .i_arready(i_arready), .i_araddr(i_araddr),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rdata(i_rdata), .i_rresp(i_rresp),
    .d_arvalid(d_arvalid), .d_arready(d_arready), .d_araddr(d_araddr),
    .d_rvalid(d_rvalid), .d_rready(d_rready), .d_rdata(d_rdata), .d_rresp(d_rresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Downstream memory model: data = addr ^ 0x113, error responses for two marked addresses.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h0000_0113;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    if (a == 32'hFFFF_FFFC) return 2'b10;
    if (a[31:16] == 16'hDEAD) return 2'b11;
    return 2'b00;
  endfunction

  int          ar_dly = 0;
  int          r_dly  = 0;
  logic [31:0] log_addr[$];
  logic [2:0]  log_prot[$];

  initial begin
    logic [31:0] cap;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (!resetn || !m_arvalid) continue;
      repeat (ar_dly) @(negedge clk);
      m_arready = 1'b1;
      @(posedge clk);
      cap = m_araddr;
      log_addr.push_back(m_araddr);
      log_prot.push_back(m_arprot);
      @(negedge clk);
      m_arready = 1'b0;
      repeat (r_dly) @(negedge clk);
      if (!resetn) continue;
      m_rdata  = mem_data(cap);
      m_rresp  = mem_resp(cap);
      m_rvalid = 1'b1;
      while (!m_rready && resetn) @(negedge clk);
      @(negedge clk);
      m_rvalid = 1'b0;
      m_rdata  = 32'hBAD0_BAD0;
      m_rresp  = 2'b01;
    end
  end

  // Monitors: arready pulse counts, rvalid ownership, AR hold while stalled, m_arvalid rises.
  int          cnt_i_ar = 0, cnt_d_ar = 0, ar_rises = 0;
  logic        prev_wait = 1'b0, prev_mav = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    if (resetn) begin
      if (i_arready) cnt_i_ar++;
      if (d_arready) cnt_d_ar++;
      if (i_rvalid) chk("i_rvalid_owner", {m_arprot, d_rvalid}, {3'b100, 1'b0});
      if (d_rvalid) chk("d_rvalid_owner", {m_arprot, i_rvalid}, {3'b000, 1'b0});
      if (prev_wait) chk("ar_hold", {m_arvalid, m_araddr}, {1'b1, prev_addr});
      if (m_arvalid && !prev_mav) ar_rises++;
    end
    prev_wait = resetn && m_arvalid && !m_arready;
    prev_addr = m_araddr;
    prev_mav  = m_arvalid;
  end

  task automatic run_master(input bit is_d, input logic [31:0] addr, input int rr_dly,
                            output logic [31:0] data, output logic [1:0] resp);
    int t;
    if (is_d) begin d_araddr = addr; d_arvalid = 1'b1; end
    else      begin i_araddr = addr; i_arvalid = 1'b1; end
    t = 0;
    do begin @(negedge clk); t++; end
    while (!(is_d ? d_arready : i_arready) && t < 300);
    if (!(is_d ? d_arready : i_arready)) timeout_fail("arready_wait");
    @(posedge clk); #1;
    if (is_d) d_arvalid = 1'b0; else i_arvalid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!(is_d ? d_rvalid : i_rvalid) && t < 300);
    if (!(is_d ? d_rvalid : i_rvalid)) timeout_fail("rvalid_wait");
    data = is_d ? d_rdata : i_rdata;
    resp = is_d ? d_rresp : i_rresp;
    for (int k = 0; k < rr_dly; k++) begin
      @(negedge clk);
      if (is_d) chk("r_hold", {d_rvalid, d_rresp, d_rdata}, {1'b1, resp, data});
      else      chk("r_hold", {i_rvalid, i_rresp, i_rdata}, {1'b1, resp, data});
    end
    if (is_d) d_rready = 1'b1; else i_rready = 1'b1;
    @(negedge clk);
    chk("rvalid_drop", is_d ? d_rvalid : i_rvalid, 1'b0);
    if (is_d) d_rready = 1'b0; else i_rready = 1'b0;
  endtask

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    int          ar_dly;
    int          r_dly;
    int          rr_dly;
    logic [2:0]  prot;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] di, dd;
  logic [1:0]  ri, rd;
  int          n0, ci, cd, n_req;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0100, 0, 0, 0, 3'b100, 32'h0000_0013, 2'b00};
    vecs[1] = '{1'b1, 32'h0000_2000, 0, 0, 0, 3'b000, 32'h0000_2113, 2'b00};
    vecs[2] = '{1'b1, 32'hFFFF_FFFC, 0, 0, 0, 3'b000, 32'hFFFF_FEEF, 2'b10};
    vecs[3] = '{1'b0, 32'h0000_0040, 5, 3, 0, 3'b100, 32'h0000_0153, 2'b00};
    vecs[4] = '{1'b1, 32'h1234_5678, 5, 3, 4, 3'b000, 32'h1234_576B, 2'b00};
    vecs[5] = '{1'b0, 32'hDEAD_0000, 1, 2, 2, 3'b100, 32'hDEAD_0113, 2'b11};
    n_req = 0;

    resetn = 1'b0;
    i_arvalid = 1'b0; i_araddr = '0; i_rready = 1'b0;
    d_arvalid = 1'b0; d_araddr = '0; d_rready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {m_arvalid, i_arready, d_arready, i_rvalid, d_rvalid, m_rready}, 6'b0);
    chk("reset_addr", {m_arprot, m_araddr}, 35'h0);
    chk("reset_rdata", {i_rdata, d_rdata}, 64'h0);
    chk("reset_rresp", {i_rresp, d_rresp}, 4'h0);
    resetn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      ar_dly = vecs[v].ar_dly;
      r_dly  = vecs[v].r_dly;
      n0 = log_addr.size(); ci = cnt_i_ar; cd = cnt_d_ar;
      run_master(vecs[v].is_d, vecs[v].addr, vecs[v].rr_dly, di, ri);
      n_req++;
      chk("vec_rdata", di, vecs[v].rdata);
      chk("vec_rresp", ri, vecs[v].rresp);
      chk("vec_nlog", log_addr.size(), n0 + 1);
      if (log_addr.size() > n0) begin
        chk("vec_araddr", log_addr[n0], vecs[v].addr);
        chk("vec_arprot", log_prot[n0], vecs[v].prot);
      end
      chk("vec_arready_cnt", {cnt_i_ar - ci, cnt_d_ar - cd},
          {(vecs[v].is_d ? 32'd0 : 32'd1), (vecs[v].is_d ? 32'd1 : 32'd0)});
      @(negedge clk);
    end

    // Simultaneous i/d after an i read: data port first in either arbitration mode.
    ar_dly = 0; r_dly = 0;
    n0 = log_addr.size(); ci = cnt_i_ar; cd = cnt_d_ar;
    fork
      run_master(1'b0, 32'h0000_0200, 0, di, ri);
      run_master(1'b1, 32'h0000_1000, 0, dd, rd);
    join
    n_req += 2;
    chk("tie_nlog", log_addr.size(), n0 + 2);
    if (log_addr.size() >= n0 + 2) begin
      chk("tie_first", {log_prot[n0], log_addr[n0]}, {3'b000, 32'h0000_1000});
      chk("tie_second", {log_prot[n0+1], log_addr[n0+1]}, {3'b100, 32'h0000_0200});
    end
    chk("tie_data", {di, dd}, {32'h0000_0313, 32'h0000_1113});
    chk("tie_arready_cnt", {cnt_i_ar - ci, cnt_d_ar - cd}, {32'd1, 32'd1});
    @(negedge clk);

    // Three back-to-back tied pairs: expected grant order D,I,D,I,D,I.
    for (int p = 0; p < 3; p++) begin
      n0 = log_addr.size();
      fork
        run_master(1'b0, 32'h0000_0400 + 32'(p * 16), 0, di, ri);
        run_master(1'b1, 32'h0000_8000 + 32'(p * 16), 0, dd, rd);
      join
      n_req += 2;
      chk("pair_nlog", log_addr.size(), n0 + 2);
      if (log_addr.size() >= n0 + 2)
        chk("pair_order", {log_prot[n0], log_prot[n0+1]}, {3'b000, 3'b100});
      @(negedge clk);
    end

    // After a data-only read a tie goes to the instruction port only when alternating.
    run_master(1'b1, 32'h0000_3000, 0, dd, rd);
    n_req++;
    chk("donly_rdata", dd, 32'h0000_3113);
    @(negedge clk);
    n0 = log_addr.size();
    fork
      run_master(1'b0, 32'h0000_0500, 0, di, ri);
      run_master(1'b1, 32'h0000_5000, 0, dd, rd);
    join
    n_req += 2;
    if (log_addr.size() >= n0 + 2)
      chk("tie_after_d", {log_prot[n0], log_prot[n0+1]},
          RR ? {3'b100, 3'b000} : {3'b000, 3'b100});
    else
      timeout_fail("tie_after_d");
    chk("tie_after_d_data", {di, dd}, {32'h0000_0413, 32'h0000_5113});
    @(negedge clk);

    // Reset while waiting for read data, then a fresh fetch.
    r_dly = 8;
    d_araddr = 32'h0000_7000; d_arvalid = 1'b1;
    n0 = 0;
    do begin @(negedge clk); n0++; end while (!d_arready && n0 < 50);
    @(posedge clk); #1;
    d_arvalid = 1'b0;
    n_req++;
    n0 = 0;
    while (!m_rready && n0 < 50) begin @(negedge clk); n0++; end
    chk("rst_in_data", m_rready, 1'b1);
    resetn = 1'b0;
    #1;
    chk("rst_ctrl", {m_arvalid, m_rready, i_rvalid, d_rvalid, i_arready, d_arready}, 6'b0);
    chk("rst_addr", {m_arprot, m_araddr}, 35'h0);
    chk("rst_rdata", {i_rdata, d_rdata, i_rresp, d_rresp}, 68'h0);
    repeat (12) @(negedge clk);
    r_dly = 0;
    resetn = 1'b1;
    @(negedge clk);
    n0 = log_addr.size();
    run_master(1'b0, 32'h0000_0000, 0, di, ri);
    n_req++;
    chk("post_rst_data", {ri, di}, {2'b00, 32'h0000_0113});
    if (log_addr.size() > n0)
      chk("post_rst_prot", {log_prot[n0], log_addr[n0]}, {3'b100, 32'h0});
    else
      timeout_fail("post_rst_prot");
    repeat (3) @(negedge clk);
    chk("ar_rises", ar_rises, n_req);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
